// File: rtl/multiplier_arbiter_pkg.sv
// Shared types for the two-requester front end of one multiplier.
// State encoding and owner id live here so the arbiter and top agree.
package multiplier_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_e;

    localparam int OWNER_W = 1;

    typedef logic [OWNER_W-1:0] owner_t;

    function automatic logic [1:0] owner_onehot(input owner_t id);
        owner_onehot = 2'b01 << id;
    endfunction

endpackage

// File: rtl/multiplier_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes
// to the requester named by prio.
module rr_arbiter2
    import multiplier_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     prio,
    output logic [1:0] grant,
    output owner_t     grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = '0;
        if (req == 2'b11) begin
            grant_id = prio;
            grant    = owner_onehot(prio);
        end else if (req[1]) begin
            grant_id = owner_t'(1);
            grant    = 2'b10;
        end else if (req[0]) begin
            grant_id = owner_t'(0);
            grant    = 2'b01;
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one external multiplier between two requesters, one transaction
// at a time, with a completion timeout and per-requester responses.
module multiplier_arbiter
    import multiplier_arbiter_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 2*WIDTH+8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req0_multiplier,
    input  logic [WIDTH-1:0]   req0_multiplicand,
    input  logic [WIDTH-1:0]   req1_multiplier,
    input  logic [WIDTH-1:0]   req1_multiplicand,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_timeout,
    output logic               mult_start,
    output logic [WIDTH-1:0]   mult_multiplier,
    output logic [WIDTH-1:0]   mult_multiplicand,
    input  logic [2*WIDTH-1:0] mult_product,
    input  logic               mult_productDone,
    output logic               busy
);

    localparam int CNT_W = $clog2(TIMEOUT+1);

    state_e             state_q, state_d;
    owner_t             owner_q, owner_d;
    owner_t             prio_q, prio_d;
    owner_t             grant_id;
    logic [1:0]         grant;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               timeout_q, timeout_d;
    logic               start_q, start_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    rr_arbiter2 u_rr (
        .req      (req_valid),
        .prio     (prio_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grant is offered combinationally so a withdrawn request is never taken.
    assign req_ready         = (state_q == ST_IDLE && !rst) ? grant : 2'b00;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_product       = prod_q;
    assign rsp_timeout       = timeout_q;
    assign mult_start        = start_q;
    assign mult_multiplier   = op_a_q;
    assign mult_multiplicand = op_b_q;
    assign busy              = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        prod_d      = prod_q;
        timeout_d   = timeout_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant_id;
                    op_a_d  = grant_id[0] ? req1_multiplier
                                          : req0_multiplier;
                    op_b_d  = grant_id[0] ? req1_multiplicand
                                          : req0_multiplicand;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_productDone) begin
                    prod_d      = mult_product;
                    timeout_d   = 1'b0;
                    rsp_valid_d = owner_onehot(owner_q);
                    state_d     = ST_RESPOND;
                end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                    prod_d      = '0;
                    timeout_d   = 1'b1;
                    rsp_valid_d = owner_onehot(owner_q);
                    state_d     = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                if ((rsp_ready & rsp_valid_q) != 2'b00) begin
                    rsp_valid_d = 2'b00;
                    prio_d      = ~owner_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            prio_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            prod_q      <= '0;
            timeout_q   <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            prod_q      <= prod_d;
            timeout_q   <= timeout_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: transaction-level model plus directed
// scenarios against a behavioural multiplier with programmable latency.
module tb_multiplier_arbiter;

    localparam int W  = 128;
    localparam int TO = 2*W+8;
    localparam logic [2*W-1:0] MAXP =
        {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b00;
    logic [2*W-1:0] rsp_product;
    logic         rsp_timeout;
    logic         mult_start;
    logic [W-1:0] mm, mc;
    logic [2*W-1:0] mult_product;
    logic         mult_productDone;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req0_multiplier   (a0),
        .req0_multiplicand (b0),
        .req1_multiplier   (a1),
        .req1_multiplicand (b1),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_product       (rsp_product),
        .rsp_timeout       (rsp_timeout),
        .mult_start        (mult_start),
        .mult_multiplier   (mm),
        .mult_multiplicand (mc),
        .mult_product      (mult_product),
        .mult_productDone  (mult_productDone),
        .busy              (busy)
    );

    task automatic chk(input string nm, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural multiplier: done mul_lat cycles after the start cycle.
    int mul_lat = 4;
    bit mul_never = 0;
    bit stray = 0;
    int left = 0;
    logic [2*W-1:0] pa, pb;

    initial begin
        mult_productDone = 1'b0;
        mult_product = '0;
        forever begin
            @(posedge clk);
            #1;
            mult_productDone = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    mult_productDone = 1'b1;
                    mult_product = pa * pb;
                end
            end
            if (mult_start && !mul_never) begin
                left = mul_lat;
                pa = {{W{1'b0}}, mm};
                pb = {{W{1'b0}}, mc};
            end
            if (stray) begin
                mult_productDone = 1'b1;
                mult_product = {(2*W){1'b1}};
            end
        end
    end

    function automatic logic [1:0] pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Transaction model: timing expressed as cycles since acceptance.
    bit m_act = 0, m_res = 0, m_dprev = 0, m_own = 0, m_prio = 0, m_to = 0;
    int m_cyc = 0;
    logic [2*W-1:0] m_a, m_b, m_p;
    int lg_own[$];
    logic [2*W-1:0] lg_prod[$];
    int n_rdy0 = 0, n_start = 0, n_rv = 0;

    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            n_rdy0 += int'(req_ready[0]);
            n_start += int'(mult_start);
            n_rv += int'(rsp_valid != 2'b00);
            if (rst) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_mult_start", mult_start, 0);
                chk("rst_rsp_product", rsp_product, 0);
                chk("rst_mult_multiplier", mm, 0);
                m_act = 0;
                m_res = 0;
                m_prio = 0;
            end else if (!m_act) begin
                e = pick(req_valid, m_prio);
                chk("req_ready", req_ready, e);
                chk("busy_idle", busy, 0);
                chk("rsp_valid_idle", rsp_valid, 0);
                chk("mult_start_idle", mult_start, 0);
                if (e != 2'b00) begin
                    m_act = 1;
                    m_own = e[1];
                    m_a = e[1] ? a1 : a0;
                    m_b = e[1] ? b1 : b0;
                    m_cyc = 0;
                    m_res = 0;
                    m_dprev = 0;
                end
            end else begin
                m_cyc++;
                chk("req_ready_busy", req_ready, 0);
                chk("busy", busy, 1);
                chk("mult_start", mult_start, m_cyc == 1);
                chk("mult_multiplier", mm, m_a);
                chk("mult_multiplicand", mc, m_b);
                if (!m_res && m_dprev) begin
                    m_res = 1;
                    m_p = m_a * m_b;
                    m_to = 0;
                end else if (!m_res && m_cyc == 2 + TO) begin
                    m_res = 1;
                    m_p = '0;
                    m_to = 1;
                end
                chk("rsp_valid", rsp_valid,
                    m_res ? (m_own ? 2'b10 : 2'b01) : 2'b00);
                if (m_res) begin
                    chk("rsp_product", rsp_product, m_p);
                    chk("rsp_timeout", rsp_timeout, m_to);
                    if (rsp_ready[m_own]) begin
                        m_act = 0;
                        m_prio = !m_own;
                        lg_own.push_back(int'(m_own));
                        lg_prod.push_back(rsp_product);
                    end
                end
                m_dprev = !m_res && m_cyc >= 2 && mult_productDone;
            end
        end
    end

    task automatic wait_rv(input int budget, output int n);
        n = 0;
        while (rsp_valid == 2'b00 && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_rsp_valid", rsp_valid != 2'b00, 1);
    endtask

    task automatic wait_log(input int target, input int budget);
        int n = 0;
        while (lg_own.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_log", lg_own.size() >= target, 1);
    endtask

    initial begin
        int n, k, r0, s0, v0;
        tick(3);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_timeout", rsp_timeout, 0);
        rst = 1'b0;
        tick(2);

        stray = 1;
        tick(3);
        stray = 0;
        tick(1);
        chk("stray_done_busy", busy, 0);

        mul_lat = 5;
        a0 = 7; b0 = 9; a1 = 2; b1 = 11;
        k = lg_own.size();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        wait_log(k + 3, 200);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        if (lg_own.size() >= k + 3) begin
            chk("cont_owner0", lg_own[k], 0);
            chk("cont_owner1", lg_own[k+1], 1);
            chk("cont_owner2", lg_own[k+2], 0);
            chk("cont_prod0", lg_prod[k], 63);
            chk("cont_prod1", lg_prod[k+1], 22);
            chk("cont_prod2", lg_prod[k+2], 63);
        end
        tick(2);

        r0 = n_rdy0;
        s0 = n_start;
        mul_lat = 130;
        a0 = 3; b0 = 5;
        req_valid = 2'b01;
        tick(1);
        req_valid = 2'b00;
        chk("single_start", mult_start, 1);
        wait_rv(400, n);
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_product", rsp_product, 15);
        chk("single_timeout", rsp_timeout, 0);
        rsp_ready = 2'b01;
        tick(1);
        rsp_ready = 2'b00;
        tick(1);
        chk("single_ready_pulses", n_rdy0 - r0, 1);
        chk("single_start_pulses", n_start - s0, 1);

        mul_lat = 3;
        a0 = 6; b0 = 7;
        req_valid = 2'b01;
        tick(1);
        req_valid = 2'b00;
        wait_rv(50, n);
        for (int i = 0; i < 10; i++) begin
            rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
            tick(1);
            chk("bp_valid", rsp_valid, 2'b01);
            chk("bp_product", rsp_product, 42);
        end
        rsp_ready = 2'b01;
        tick(1);
        rsp_ready = 2'b00;
        chk("bp_released", rsp_valid, 2'b00);

        mul_never = 1;
        a1 = 4; b1 = 4;
        req_valid = 2'b10;
        tick(1);
        req_valid = 2'b00;
        chk("to_start", mult_start, 1);
        wait_rv(TO + 50, n);
        chk("to_latency", n - 1, TO);
        chk("to_flag", rsp_timeout, 1);
        chk("to_product", rsp_product, 0);
        chk("to_owner", rsp_valid, 2'b10);
        rsp_ready = 2'b10;
        tick(1);
        rsp_ready = 2'b00;
        mul_never = 0;

        mul_lat = 2;
        a0 = '1; b0 = '1;
        req_valid = 2'b01;
        tick(1);
        req_valid = 2'b00;
        wait_rv(20, n);
        chk("max_product", rsp_product, MAXP);
        rsp_ready = 2'b01;
        tick(1);
        rsp_ready = 2'b00;

        mul_lat = 100;
        a1 = 5; b1 = 5;
        req_valid = 2'b10;
        tick(1);
        req_valid = 2'b00;
        chk("rw_start", mult_start, 1);
        tick(50);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_async_busy", busy, 0);
        chk("rw_async_rsp_valid", rsp_valid, 0);
        chk("rw_async_multiplier", mm, 0);
        chk("rw_async_multiplicand", mc, 0);
        chk("rw_async_product", rsp_product, 0);
        chk("rw_async_timeout", rsp_timeout, 0);
        tick(1);
        rst = 1'b0;
        v0 = n_rv;
        rsp_ready = 2'b11;
        tick(80);
        rsp_ready = 2'b00;
        chk("rw_no_response", n_rv - v0, 0);

        mul_lat = 3;
        a0 = 7; b0 = 9; a1 = 2; b1 = 11;
        k = lg_own.size();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        wait_log(k + 1, 100);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        if (lg_own.size() > k) begin
            chk("post_rst_owner", lg_own[k], 0);
            chk("post_rst_product", lg_prod[k], 63);
        end
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 128: operand width; product width is 2*WIDTH.
REQ-002 SHALL have parameter TIMEOUT, default 2*WIDTH+8: maximum cycles to wait for multiplier completion.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid  input  2  and req_ready  output  2: per-requester request handshake, bit i for requester i.
REQ-006 SHALL have ports req0_multiplier, req0_multiplicand, req1_multiplier, req1_multiplicand  input  WIDTH  operands.
REQ-007 SHALL have ports rsp_valid  output  2  and rsp_ready  input  2: per-requester response handshake.
REQ-008 SHALL have ports rsp_product  output  2*WIDTH  and rsp_timeout  output  1: shared response payload.
REQ-009 SHALL have ports mult_start  output  1, mult_multiplier and mult_multiplicand  output  WIDTH: drive to shared multiplier.
REQ-010 SHALL have ports mult_product  input  2*WIDTH  and mult_productDone  input  1: from shared multiplier.
REQ-011 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE; no other transitions except reset.
REQ-013 IDLE: with any req_valid high, SHALL grant one requester, pulse its req_ready for exactly one cycle, latch its operands and owner id, go to ISSUE.
REQ-014 Arbitration SHALL be round-robin: single requester always wins; both valid -> requester not granted last wins; after reset requester 0 has priority.
REQ-015 Round-robin pointer SHALL update only on RESPOND exit, never on timeout-free idle cycles.
REQ-016 ISSUE: SHALL assert mult_start for exactly one cycle with latched operands on mult_multiplier/mult_multiplicand, go to WAIT.
REQ-017 mult_multiplier/mult_multiplicand SHALL hold latched operands stable from ISSUE through WAIT.
REQ-018 WAIT: on mult_productDone high, SHALL latch mult_product, clear timeout flag, go to RESPOND.
REQ-019 WAIT: cycle counter SHALL start at 0 on WAIT entry; if it reaches TIMEOUT without productDone, SHALL latch product 0, set rsp_timeout, go to RESPOND.
REQ-020 mult_productDone outside WAIT SHALL be ignored.
REQ-021 RESPOND: SHALL assert rsp_valid only on owner bit, with rsp_product/rsp_timeout stable, until rsp_ready on that bit is high; that cycle SHALL complete transfer and return to IDLE.
REQ-022 rsp_ready on the non-owner bit SHALL have no effect.
REQ-023 Latency: req accept (cycle 0) -> mult_start cycle 1 -> RESPOND one cycle after productDone sampled.
REQ-024 req_ready SHALL never be asserted outside IDLE; new requests wait, no queuing.
REQ-025 req_valid deasserted by the requester before grant SHALL be treated as withdrawn; no grant issued.

Reset
REQ-026 On rst high SHALL immediately force IDLE; req_ready, rsp_valid, mult_start, rsp_timeout, busy = 0; rsp_product, mult operands, counter = 0; RR pointer -> requester 0.
REQ-027 Reset mid-operation (ISSUE/WAIT/RESPOND) SHALL abandon the transaction with no response; a later productDone SHALL be ignored.

Structure
REQ-028 State encoding and owner-id width SHALL reside in shared package multiplier_arbiter_pkg.
REQ-029 Round-robin grant logic SHALL be one sub-module, rr_arbiter2; the multiplier itself SHALL be instantiated outside this block.

Verification
REQ-030 Single request: req_valid=01, operands 3 x 5, multiplier model done after 130 cycles -> req_ready[0] one pulse, mult_start one pulse, rsp_valid=01, rsp_product=15, rsp_timeout=0.
REQ-031 Contention: req_valid=11 held, operands (7,9) and (2,11) -> order 0 then 1 then 0; products 63, 22, 63; never two req_ready bits high.
REQ-032 Timeout: model never raises productDone -> rsp_timeout=1, rsp_product=0 exactly TIMEOUT cycles after WAIT entry.
REQ-033 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_product stable; rsp_ready[1] pulses ignored while owner=0.
REQ-034 Reset in WAIT: rst pulsed 50 cycles after mult_start -> all outputs 0 asynchronously, busy=0, late productDone produces no rsp_valid.
REQ-035 Max operands: 2^WIDTH-1 squared -> rsp_product = 2^(2*WIDTH) - 2^(WIDTH+1) + 1, no truncation.
